// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: FSM state type and default timing constants shared by the
// freq_meter block and its optional BCD converter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2,
    CONV  = 2'd3
  } state_e;

  localparam int CLK_HZ          = 48_000_000;
  localparam int DEF_GATE_CYCLES = CLK_HZ;  // one-second gate at the nominal clock
  localparam int DEF_CNT_WIDTH   = 24;
  localparam int DEF_BCD_DIGITS  = 8;

endpackage

// File: rtl/freq_meter_bcd.sv
// freq_meter_bcd: sequential double-dabble converter, one bit per cycle for BIN_W cycles.
// done is high in the final iteration cycle, when bcd already shows the finished result.
module freq_meter_bcd
  import freq_meter_pkg::*;
#(
  parameter int BIN_W  = DEF_CNT_WIDTH,
  parameter int DIGITS = DEF_BCD_DIGITS
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int SH_W   = 4 * DIGITS + BIN_W;
  localparam int ITER_W = $clog2(BIN_W + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BIN_W - 1);

  logic [SH_W-1:0]   sh_r;
  logic [SH_W-1:0]   step_s;
  logic [ITER_W-1:0] iter_r;
  logic              run_r;

  // Add 3 to every BCD digit of 5 or more, then shift the whole register left.
  function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] a;
    a = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[BIN_W + 4*d +: 4] >= 4'd5) begin
        a[BIN_W + 4*d +: 4] = a[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
    return {a[SH_W-2:0], 1'b0};
  endfunction

  assign step_s = dabble_step(sh_r);
  assign bcd    = step_s[SH_W-1 -: 4*DIGITS];
  assign done   = run_r && (iter_r == ITER_LAST);

  // Load the binary value on start, then iterate until the last bit is shifted in.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sh_r   <= '0;
      iter_r <= '0;
      run_r  <= 1'b0;
    end else if (start) begin
      sh_r   <= {{(4*DIGITS){1'b0}}, bin};
      iter_r <= '0;
      run_r  <= 1'b1;
    end else if (run_r) begin
      sh_r   <= step_s;
      iter_r <= iter_r + ITER_W'(1);
      run_r  <= !done;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over back-to-back GATE_CYCLES-long windows.
// Optional macro FREQ_METER_BCD_EN adds bcd_out via a sequential BCD conversion state.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int BCD_DIGITS  = DEF_BCD_DIGITS
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   sig_in,
  input  logic                   en,
  output logic [CNT_WIDTH-1:0]   freq_out,
  output logic                   valid,
  output logic                   ovf,
  output logic                   busy
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [4*BCD_DIGITS-1:0] bcd_out
`endif
);

  localparam int TMR_W = $clog2(GATE_CYCLES + 1);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  if (GATE_CYCLES < 4 || CNT_WIDTH < 1 || BCD_DIGITS < 1) begin : g_bad_params
    $error("freq_meter: needs GATE_CYCLES >= 4, CNT_WIDTH >= 1, BCD_DIGITS >= 1");
  end

  state_e                 state_r, state_nxt_s;
  logic                   sync1_r, sync2_r, prev_r;
  logic                   edge_s, gate_done_s, gate_entry_s;
  logic [TMR_W-1:0]       tmr_r;
  logic [CNT_WIDTH-1:0]   cnt_r, cnt_nxt_s;
  logic                   ovf_flag_r, ovf_nxt_s;

  assign edge_s       = sync2_r & ~prev_r;
  assign gate_done_s  = (tmr_r == TMR_LAST);
  assign gate_entry_s = (state_r != GATE) && (state_nxt_s == GATE);

`ifdef FREQ_METER_BCD_EN
  logic                    conv_done_s;
  logic [4*BCD_DIGITS-1:0] conv_bcd_s;

  freq_meter_bcd #(
    .BIN_W  (CNT_WIDTH),
    .DIGITS (BCD_DIGITS)
  ) u_bcd (
    .clk_in (clk_in),
    .rst    (rst),
    .start  (state_r == LATCH),
    .bin    (cnt_r),
    .bcd    (conv_bcd_s),
    .done   (conv_done_s)
  );
`endif

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; dropping en inside a gate window aborts it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) state_nxt_s = GATE;
        else    state_nxt_s = IDLE;
      end
      GATE: begin
        if (!en)              state_nxt_s = IDLE;
        else if (gate_done_s) state_nxt_s = LATCH;
        else                  state_nxt_s = GATE;
      end
`ifdef FREQ_METER_BCD_EN
      LATCH: state_nxt_s = CONV;
      CONV: begin
        if (!conv_done_s) state_nxt_s = CONV;
        else if (en)      state_nxt_s = GATE;
        else              state_nxt_s = IDLE;
      end
`else
      LATCH: begin
        if (en) state_nxt_s = GATE;
        else    state_nxt_s = IDLE;
      end
      CONV: state_nxt_s = IDLE;
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // Saturating edge count for the current gate cycle.
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = ovf_flag_r;
    if (edge_s) begin
      if (cnt_r == CNT_MAX) begin
        ovf_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Gate timer and edge counter; an edge seen in LATCH seeds the next window.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      tmr_r      <= '0;
      cnt_r      <= '0;
      ovf_flag_r <= 1'b0;
    end else if (gate_entry_s) begin
      tmr_r      <= '0;
      cnt_r      <= CNT_WIDTH'((state_r == LATCH) && edge_s);
      ovf_flag_r <= 1'b0;
    end else if (state_r == GATE) begin
      tmr_r      <= tmr_r + TMR_W'(1);
      cnt_r      <= cnt_nxt_s;
      ovf_flag_r <= ovf_nxt_s;
    end
  end

  // Registered results; loaded so that valid is high in the cycle the result appears.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      freq_out <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
`ifdef FREQ_METER_BCD_EN
      bcd_out  <= '0;
`endif
    end else begin
      busy <= (state_nxt_s != IDLE);
`ifdef FREQ_METER_BCD_EN
      if (state_r == CONV && conv_done_s) begin
        freq_out <= cnt_r;
        ovf      <= ovf_flag_r;
        bcd_out  <= conv_bcd_s;
        valid    <= 1'b1;
      end else begin
        valid    <= 1'b0;
      end
`else
      if (state_r == GATE && state_nxt_s == LATCH) begin
        freq_out <= cnt_nxt_s;
        ovf      <= ovf_nxt_s;
        valid    <= 1'b1;
      end else begin
        valid    <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: two freq_meter instances (CNT_WIDTH 8 and 5) share random stimulus;
// a per-lane window model queues expected results, a per-lane monitor checks them.
module tb_freq_meter;

  localparam int GATE = 100;

  typedef struct packed {
    int cyc;
    int cnt;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst;
  logic sig_in;
  logic en;

  int n_checks = 0;
  int n_pass   = 0;
  int sig_mode = 0;   // 0 periodic, 1 constant 0, 2 constant 1, 3 random bits
  int sig_per  = 10;
  int sig_ph   = 0;
  int waited;

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

`ifdef FREQ_METER_BCD_EN
  function automatic longint to_bcd(input int v);
    longint r;
    int     x;
    r = 0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r = r | (longint'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction
`endif

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int W    = (g == 0) ? 8 : 5;
    localparam int MAXV = (1 << W) - 1;

    logic [W-1:0] freq_out;
    logic         valid, ovf, busy;
`ifdef FREQ_METER_BCD_EN
    logic [31:0]  bcd_out;
`endif

    freq_meter #(
      .GATE_CYCLES (GATE),
      .CNT_WIDTH   (W),
      .BCD_DIGITS  (8)
    ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .sig_in   (sig_in),
      .en       (en),
      .freq_out (freq_out),
      .valid    (valid),
      .ovf      (ovf),
      .busy     (busy)
`ifdef FREQ_METER_BCD_EN
      ,
      .bcd_out  (bcd_out)
`endif
    );

    // Window model: pos = -1 idle, 0..GATE-1 gate cycle index, >= GATE after the gate.
    exp_t       q[$];
    int         cyc = 0;
    int         pos = -1;
    int         n = 0;
    int         det;
    bit         exp_busy = 1'b0;
    logic [2:0] hist = 3'b000;   // hist[0] = newest sampled sig_in

    initial forever begin
      @(posedge clk_in or negedge rst);
      if (!rst) begin
        pos = -1; n = 0; hist = 3'b000; exp_busy = 1'b0;
        q.delete();
      end else begin
        cyc++;
        det = (hist[1] && !hist[2]) ? 1 : 0;   // edge seen by the DUT in this cycle
        if (pos < 0) begin
          if (en) begin pos = 0; n = 0; end
        end else if (pos < GATE) begin
          if (!en) pos = -1;
          else begin
            n += det;
            pos++;
`ifndef FREQ_METER_BCD_EN
            if (pos == GATE) q.push_back('{cyc, n});
`endif
          end
`ifdef FREQ_METER_BCD_EN
        end else if (pos < GATE + W) begin
          pos++;
        end else begin
          q.push_back('{cyc, n});
          pos = en ? 0 : -1;
          n = 0;
        end
`else
        end else begin
          pos = en ? 0 : -1;
          n = det;
        end
`endif
        hist = {hist[1:0], sig_in};
        exp_busy = (pos >= 0);
      end
    end

    // Monitor: pops an expectation exactly in the cycle valid is due.
    exp_t e;
    int   last_f = 0;
    bit   last_o = 1'b0;
    initial forever begin
      @(negedge clk_in);
      if (!rst) begin
        last_f = 0; last_o = 1'b0;
      end
      if (q.size() > 0 && q[0].cyc == cyc && rst) begin
        e = q.pop_front();
        check($sformatf("w%0d valid pulse", W), valid, 1);
        last_f = (e.cnt > MAXV) ? MAXV : e.cnt;
        last_o = (e.cnt > MAXV);
      end else begin
        check($sformatf("w%0d valid idle", W), valid, 0);
      end
      check($sformatf("w%0d freq_out", W), freq_out, last_f);
      check($sformatf("w%0d ovf", W), ovf, last_o);
      check($sformatf("w%0d busy", W), busy, exp_busy);
`ifdef FREQ_METER_BCD_EN
      check($sformatf("w%0d bcd_out", W), bcd_out, rst ? to_bcd(last_f) : 0);
`endif
    end
  end

  // Input pattern generator for sig_in.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk_in);
      #1;
      case (sig_mode)
        0: begin
          sig_ph = (sig_ph + 1) % sig_per;
          sig_in = (sig_ph < sig_per / 2);
        end
        1:       sig_in = 1'b0;
        2:       sig_in = 1'b1;
        default: sig_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk_in);
    #1;
  endtask

  // Returns at the negedge where lane 0 shows valid, or after a bounded wait.
  task automatic wait_valid(input string tag, output int w);
    w = 0;
    do begin
      @(negedge clk_in);
      w++;
    end while (!g_lane[0].valid && w < 400);
    check({tag, " valid seen"}, g_lane[0].valid, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " w8 freq_out"}, g_lane[0].freq_out, 0);
    check({tag, " w8 valid"},    g_lane[0].valid, 0);
    check({tag, " w8 ovf"},      g_lane[0].ovf, 0);
    check({tag, " w8 busy"},     g_lane[0].busy, 0);
    check({tag, " w5 freq_out"}, g_lane[1].freq_out, 0);
    check({tag, " w5 valid"},    g_lane[1].valid, 0);
    check({tag, " w5 ovf"},      g_lane[1].ovf, 0);
    check({tag, " w5 busy"},     g_lane[1].busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    repeat (3) @(negedge clk_in);
    check_zero("reset");
    #1;
    rst = 1'b1;

    // Period-10 input: the first window after idle holds exactly 10 edges.
    cycles(4);
    en = 1'b1;
    wait_valid("first window", waited);
    check("first window w8 freq_out", g_lane[0].freq_out, 10);
    check("first window w8 ovf", g_lane[0].ovf, 0);
    #1;

    // Abort the second window halfway through.
    cycles(50);
    en = 1'b0;
    @(negedge clk_in);
    check("abort w8 busy", g_lane[0].busy, 0);
    check("abort w8 freq_out hold", g_lane[0].freq_out, 10);
    #1;

    // Constant levels give no counts once the level is settled.
    sig_mode = 1;
    cycles(120);
    en = 1'b1;
    wait_valid("const0", waited);
    check("const0 w8 freq_out", g_lane[0].freq_out, 0);
    #1;
    sig_mode = 2;
    wait_valid("const1 step", waited);
    wait_valid("const1", waited);
    check("const1 w8 freq_out", g_lane[0].freq_out, 0);
    #1;

    // Period-2 input saturates the 5-bit lane, then period 10 recovers.
    sig_mode = 0;
    sig_per  = 2;
    wait_valid("sat step", waited);
    wait_valid("sat", waited);
    check("sat w5 freq_out", g_lane[1].freq_out, 31);
    check("sat w5 ovf", g_lane[1].ovf, 1);
    #1;
    en = 1'b0;
    sig_per = 10;
    cycles(5);
    en = 1'b1;
    wait_valid("recover", waited);
    check("recover w5 freq_out", g_lane[1].freq_out, 10);
    check("recover w5 ovf", g_lane[1].ovf, 0);
    #1;

    // Reset in the middle of a window, then a fresh window with en held high.
    cycles(30);
    rst = 1'b0;
    #1;
    check_zero("mid-window reset");
    cycles(2);
    rst = 1'b1;
    wait_valid("restart", waited);
`ifdef FREQ_METER_BCD_EN
    check("restart latency", waited, GATE + 1 + 8 + 1);
`else
    check("restart latency", waited, GATE + 1);
`endif
    #1;

    // Random input patterns with occasional en drops.
    repeat (12) begin
      sig_mode = $urandom_range(0, 3);
      sig_per  = $urandom_range(2, 16);
      cycles($urandom_range(30, 220));
      if ($urandom_range(0, 2) == 0) begin
        en = 1'b0;
        cycles($urandom_range(1, 8));
        en = 1'b1;
      end
    end

    en = 1'b0;
    cycles(GATE + 20);
    check("w8 expectations drained", g_lane[0].q.size(), 0);
    check("w5 expectations drained", g_lane[1].q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
